// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, LSB first.
// One operand bit pair is consumed per clock through a single full-subtractor
// cell; the result is presented with a valid/ready handshake.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed overflow output 'ovf'.

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             out_ready,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Counter is wide enough to hold WIDTH itself, so it never wraps mid-operation.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             ai;
    logic             bi;
    logic             d;
    logic             br_next;
    logic             last_bit;
    logic [WIDTH-1:0] res_next;

    // Full-subtractor cell on the current LSBs; the new difference bit enters at the MSB
    // so that after WIDTH shifts the result register holds the difference in order.
    always_comb begin
        ai       = a_sr[0];
        bi       = b_sr[0];
        d        = ai ^ bi ^ br;
        br_next  = (~ai & bi) | (~(ai ^ bi) & br);
        res_next = {d, res_sr[WIDTH-1:1]};
        last_bit = (cnt == CW'(WIDTH - 1));
    end

    // Control FSM and datapath; all outputs are registered and only change on
    // acceptance, on entry to DONE, on consumption, or on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf       <= 1'b0;
`endif
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            br        <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        res_sr <= '0;
                        br     <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    br     <= br_next;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        // On the final bit, ai/bi are the operand MSBs and d is the result MSB.
                        diff      <= res_next;
                        borrow    <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                        ovf       <= (ai ^ bi) & (d ^ ai);
`endif
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
